// File: rtl/rs232out_sched_pkg.sv
// Shared definitions for the rs232out transmit scheduler: line terminator,
// FSM state encoding and the idle-release counter width.
package rs232out_sched_pkg;

  localparam logic [7:0] LF    = 8'h0A;
  localparam int         CNT_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  // Saturating increment for the idle counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rs232out_sched_rr_pick.sv
// Combinational round-robin picker: returns the first requester with valid set,
// searching upward from last+1 with wrap-around.
module rs232out_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan NREQ candidates starting just after the previous owner
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      cand = sum[IDX_W-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rs232out_sched.sv
// Round-robin transmit scheduler in front of rs232out. Grants one producer at a
// time (per line of text, or per byte), stages one byte for the transmitter and
// forcibly releases an owner that goes quiet for too long.
module rs232out_sched
  import rs232out_sched_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int LINE_LOCK    = 1,
  parameter int IDLE_RELEASE = 1023
) (
  input  logic              clk25MHz,
  input  logic              rst,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [7:0]         hold_data_q, hold_data_d;
  logic               hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               own_valid;
  logic [7:0]         own_data;
  logic               own_ready;
  logic               consume;
  logic               idle_hit;
  logic               line_end;
  logic               release_now;

  rs232out_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .last      (last_q),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // The transmitter write is combinational on busy so a staged byte leaves
  // the very cycle the line frees up.
  assign tx_data   = hold_data_q;
  assign tx_we     = hold_valid_q & ~tx_busy;
  assign grant     = grant_q;

  assign own_valid = req_valid[own_q];
  assign own_data  = req_data[{own_q, 3'b000} +: 8];
  // Owner may refill staging when it is empty or is being emptied this cycle
  assign own_ready = (state_q == ST_OWNED) & (~hold_valid_q | tx_we);
  assign consume   = own_ready & own_valid;
  assign idle_hit  = ~own_valid &
                     (({1'b0, idle_cnt_q} + (CNT_W+1)'(1)) >= (CNT_W+1)'(IDLE_RELEASE));
  assign line_end  = (LINE_LOCK != 0) ? (own_data == LF) : 1'b1;
  assign release_now = (state_q == ST_OWNED) & ((consume & line_end) | idle_hit);

  // Only the current owner ever sees ready
  always_comb begin
    req_ready        = '0;
    req_ready[own_q] = own_ready;
  end

  // Next-state logic for ownership, staging register and idle counter
  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    last_d       = last_q;
    grant_d      = grant_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    idle_cnt_d   = idle_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_OWNED;
          own_d             = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idle_cnt_d        = '0;
        end
      end
      ST_OWNED: begin
        if (consume)         idle_cnt_d = '0;
        else if (!own_valid) idle_cnt_d = sat_inc(idle_cnt_q);
        if (release_now) begin
          state_d    = ST_IDLE;
          last_d     = own_q;
          grant_d    = '0;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    // Staging drains independently of ownership; a refill wins over a drain
    if (consume) begin
      hold_data_d  = own_data;
      hold_valid_d = 1'b1;
    end else if (tx_we) begin
      hold_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a staged byte is discarded
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      own_q        <= '0;
      last_q       <= IDX_W'(NREQ - 1);
      grant_q      <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_rs232out_sched.sv
// Bench for rs232out_sched: byte producers, a simple rs232out busy model and a
// consume/transmit scoreboard, driven by one task per scenario.
module tb_rs232out_sched;

  localparam int NREQ = 4;
  localparam int CHAR = 20;

  logic              clk25MHz = 1'b0;
  logic              rst = 1'b1;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_we;
  logic              tx_busy;

  int   busy_mode  = 0;   // 0 tied low, 1 rs232out model, 2 forced by busy_force
  logic busy_force = 1'b0;
  logic model_busy = 1'b0;
  assign tx_busy = (busy_mode == 2) ? busy_force :
                   (busy_mode == 1) ? model_busy : 1'b0;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] prod_mem [NREQ][16];
  int         prod_head [NREQ] = '{default: 0};
  int         prod_tail [NREQ] = '{default: 0};

  int checks   = 0;
  int failures = 0;

  always #20 clk25MHz = ~clk25MHz;

  rs232out_sched #(
    .NREQ         (NREQ),
    .LINE_LOCK    (1),
    .IDLE_RELEASE (1023)
  ) dut (
    .clk25MHz  (clk25MHz),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_busy   (tx_busy)
  );

  // Environment: producers, busy model, consume and transmit scoreboard
  initial begin : env
    logic [NREQ-1:0] fire;
    logic            we_s;
    int              bcnt;
    exp_t            e;
    logic [7:0]      b;
    bcnt = 0;
    forever begin
      @(negedge clk25MHz);
      fire = req_valid & req_ready;
      we_s = tx_we;
      if (rst) begin
        tx_q.delete();
        fire = '0;
        we_s = 1'b0;
      end else begin
        if (fire != '0) begin
          checks++;
          if ($countones(fire) != 1) begin
            failures++;
            $display("FAIL consume_onehot got=%b want=one-hot", fire);
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          if (fire[i]) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL consume_order got=r%0d:%02h want=nothing", i, req_data[8*i +: 8]);
            end else begin
              e = exp_q.pop_front();
              tx_q.push_back(e.data);
              if (i != e.idx || req_data[8*i +: 8] !== e.data) begin
                failures++;
                $display("FAIL consume_order got=r%0d:%02h want=r%0d:%02h",
                         i, req_data[8*i +: 8], e.idx, e.data);
              end
            end
          end
        end
        if (tx_we) begin
          checks++;
          if (tx_q.size() == 0) begin
            failures++;
            $display("FAIL tx_byte got=%02h want=no write", tx_data);
          end else begin
            b = tx_q.pop_front();
            if (tx_data !== b) begin
              failures++;
              $display("FAIL tx_byte got=%02h want=%02h", tx_data, b);
            end
          end
        end
      end
      @(posedge clk25MHz);
      #1;
      if (rst)           bcnt = 0;
      else if (we_s)     bcnt = CHAR;
      else if (bcnt > 0) bcnt--;
      model_busy = (bcnt != 0);
      for (int i = 0; i < NREQ; i++) if (fire[i]) prod_head[i]++;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]       = (prod_head[i] != prod_tail[i]);
        req_data[8*i +: 8] = prod_mem[i][prod_head[i] % 16];
      end
    end
  end

  initial begin : watchdog
    #(40 * 20000);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic offer(input int r, input logic [7:0] d);
    prod_mem[r][prod_tail[r] % 16] = d;
    prod_tail[r]++;
  endtask

  task automatic expect_cons(input int r, input logic [7:0] d);
    exp_t e;
    e.idx  = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk25MHz);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || tx_q.size() != 0 || grant != '0 || tx_busy) && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_q.size() != 0 || grant != '0 || tx_busy) begin
      failures++;
      $display("FAIL drain got=pending exp=%0d tx=%0d grant=%b want=empty",
               exp_q.size(), tx_q.size(), grant);
    end
  endtask

  task automatic wait_fire(input int r, input string nm);
    logic found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc();
      found = req_valid[r] & req_ready[r];
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s got=no consume want=consume by r%0d", nm, r);
    end
  endtask

  task automatic test_reset();
    busy_mode = 0;
    rst = 1'b1;
    repeat (3) cyc();
    checks++; if (grant !== '0)     begin failures++; $display("FAIL reset_grant got=%b want=0000", grant); end
    checks++; if (tx_we !== 1'b0)   begin failures++; $display("FAIL reset_we got=%b want=0", tx_we); end
    checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL reset_data got=%02h want=00", tx_data); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single_line();
    busy_mode = 0;
    do_reset();
    offer(2, 8'h41); expect_cons(2, 8'h41);
    offer(2, 8'h0A); expect_cons(2, 8'h0A);
    cyc();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL line_arb0 got=%b want=0000", grant); end
    cyc();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL line_grant got=%b want=0100", grant); end
    cyc();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL line_hold got=%b want=0100", grant); end
    checks++; if (tx_we !== 1'b1 || tx_data !== 8'h41) begin
      failures++; $display("FAIL line_we1 got=%b/%02h want=1/41", tx_we, tx_data); end
    cyc();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL line_release got=%b want=0000", grant); end
    checks++; if (tx_we !== 1'b1 || tx_data !== 8'h0A) begin
      failures++; $display("FAIL line_we2 got=%b/%02h want=1/0a", tx_we, tx_data); end
    wait_drain(50);
  endtask

  task automatic test_back_to_back();
    int n;
    busy_mode = 1;
    do_reset();
    offer(0, 8'h61); offer(0, 8'h62); offer(0, 8'h0A);
    offer(1, 8'h78); offer(1, 8'h79); offer(1, 8'h0A);
    expect_cons(0, 8'h61); expect_cons(0, 8'h62); expect_cons(0, 8'h0A);
    expect_cons(1, 8'h78); expect_cons(1, 8'h79); expect_cons(1, 8'h0A);
    n = 0;
    while (grant !== 4'b0001 && n < 10) begin cyc(); n++; end
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL b2b_first got=%b want=0001", grant); end
    n = 0;
    while (grant === 4'b0001 && n < 500) begin cyc(); n++; end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL b2b_gap got=%b want=0000", grant); end
    cyc();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL b2b_second got=%b want=0010", grant); end
    wait_drain(1000);
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] got [5];
    logic [NREQ-1:0] want [5];
    logic [NREQ-1:0] prev;
    int seen;
    int n;
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
    for (int k = 0; k < 5; k++) got[k] = '0;
    busy_mode = 1;
    do_reset();
    offer(0, 8'h0A); offer(1, 8'h0A); offer(2, 8'h0A); offer(3, 8'h0A); offer(0, 8'h0A);
    expect_cons(0, 8'h0A); expect_cons(1, 8'h0A); expect_cons(2, 8'h0A);
    expect_cons(3, 8'h0A); expect_cons(0, 8'h0A);
    prev = '0;
    seen = 0;
    n    = 0;
    while (seen < 5 && n < 2000) begin
      cyc();
      n++;
      if (grant != prev && grant != '0) begin
        got[seen] = grant;
        seen++;
      end
      prev = grant;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got[k] !== want[k]) begin
        failures++;
        $display("FAIL rotate_%0d got=%b want=%b", k, got[k], want[k]);
      end
    end
    wait_drain(1000);
  endtask

  task automatic test_idle_release();
    int n;
    busy_mode = 0;
    do_reset();
    offer(0, 8'h41); offer(3, 8'h42); offer(3, 8'h0A);
    expect_cons(0, 8'h41); expect_cons(3, 8'h42); expect_cons(3, 8'h0A);
    wait_fire(0, "idle_first");
    cyc();
    n = 0;
    while (grant === 4'b0001 && n < 1100) begin cyc(); n++; end
    checks++; if (n != 1023) begin failures++; $display("FAIL idle_cycles got=%0d want=1023", n); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL idle_release got=%b want=0000", grant); end
    cyc();
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL idle_next got=%b want=1000", grant); end
    wait_drain(100);
  endtask

  task automatic test_busy_hold();
    busy_mode  = 2;
    busy_force = 1'b1;
    do_reset();
    offer(1, 8'h41); offer(1, 8'h42); offer(1, 8'h0A);
    expect_cons(1, 8'h41); expect_cons(1, 8'h42); expect_cons(1, 8'h0A);
    wait_fire(1, "busy_first");
    cyc();
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (req_ready !== '0 || tx_we !== 1'b0) begin
        failures++;
        $display("FAIL busy_stall_%0d got=ready %b we %b want=ready 0000 we 0", k, req_ready, tx_we);
      end
      cyc();
    end
    busy_force = 1'b0;
    #1;
    checks++; if (tx_we !== 1'b1 || tx_data !== 8'h41) begin
      failures++; $display("FAIL busy_drain got=%b/%02h want=1/41", tx_we, tx_data); end
    checks++; if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL busy_refill got=%b want=0010", req_ready); end
    busy_mode = 0;
    wait_drain(100);
  endtask

  task automatic test_reset_mid();
    busy_mode  = 2;
    busy_force = 1'b1;
    do_reset();
    offer(1, 8'h41); offer(1, 8'h0A);
    expect_cons(1, 8'h41);
    wait_fire(1, "rstmid_first");
    repeat (3) cyc();
    rst = 1'b1;
    prod_tail[1] = prod_head[1];
    cyc();
    rst = 1'b0;
    busy_mode = 0;
    #1;
    checks++; if (grant !== '0)     begin failures++; $display("FAIL rstmid_grant got=%b want=0000", grant); end
    checks++; if (tx_we !== 1'b0)   begin failures++; $display("FAIL rstmid_we got=%b want=0", tx_we); end
    checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL rstmid_data got=%02h want=00", tx_data); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL rstmid_ready got=%b want=0000", req_ready); end
    #1;
    offer(1, 8'h43); offer(1, 8'h0A);
    expect_cons(1, 8'h43); expect_cons(1, 8'h0A);
    cyc();
    cyc();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rstmid_r1 got=%b want=0010", grant); end
    wait_drain(100);
    do_reset();
    offer(0, 8'h44); offer(0, 8'h0A); offer(1, 8'h45); offer(1, 8'h0A);
    expect_cons(0, 8'h44); expect_cons(0, 8'h0A); expect_cons(1, 8'h45); expect_cons(1, 8'h0A);
    cyc();
    cyc();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rstmid_r0 got=%b want=0001", grant); end
    wait_drain(100);
  endtask

  initial begin : main
    test_reset();
    test_single_line();
    test_back_to_back();
    test_rotation();
    test_idle_release();
    test_busy_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs232out_sched.md
# rs232out_sched

Round-robin transmit scheduler that lets NREQ independent byte producers (monitor, debug trace, CPU console, …) share the single `rs232out` serial transmitter. It holds a grant per line of text, so output from different producers is never interleaved mid-line. It also owns the one-byte staging register that drives the transmitter's `data`/`we` and observes its `busy`. The block sits between the producers and `rs232out`, in the same `clk25MHz` domain.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LINE_LOCK`, 1: 1 = hold the grant until the owner sends 8'h0A; 0 = release after every byte.
- `IDLE_RELEASE`, 1023: cycles the owner's `req_valid` may stay low before the grant is forcibly released, 1..65535.

- `clk25MHz` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_data` in 8*NREQ: byte of requester i at bits [8i+7:8i].
- `req_valid` in NREQ: requester i offers a byte.
- `req_ready` out NREQ: byte of requester i is consumed this cycle when valid & ready.
- `grant` out NREQ: one-hot current owner; 0 when idle.
- `tx_data` out 8: connects to `rs232out.data`.
- `tx_we` out 1: connects to `rs232out.we`.
- `tx_busy` in 1: connects to `rs232out.busy`.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - OWNED: one owner, index `own`.
- IDLE:
  - If any `req_valid` is set, pick the first set requester searching from `last+1` upward with wrap-around.
  - Load `own`, set `grant`, go to OWNED.
  - No byte is consumed in the arbitration cycle.
- OWNED, consume rule:
  - `req_ready[own] = ~hold_valid | tx_we`.
  - All other `req_ready` bits are 0.
  - On consume: `hold_data <= req_data[own]`, `hold_valid <= 1`, idle counter cleared.
- Staging:
  - `tx_data = hold_data`.
  - `tx_we = hold_valid & ~tx_busy`, combinational on `tx_busy`.
  - `hold_valid` clears on `tx_we` unless a new byte is consumed in the same cycle.
- Release from OWNED to IDLE, with `last <= own` and `grant <= 0`, happens on any of:
  - a consumed byte equal to 8'h0A when `LINE_LOCK = 1`;
  - any consumed byte when `LINE_LOCK = 0`;
  - the idle counter reaching `IDLE_RELEASE` while `req_valid[own]` is low.
- The idle counter increments only while OWNED and `req_valid[own]` is low. It saturates and is 16 bits wide.
- A byte consumed in the release cycle is still staged and transmitted.
- The staging register drains independently of state, so the next owner's first byte may wait on `tx_busy`.
- `req_valid` of non-owners is ignored; producers must hold valid/data stable until ready.
- Reset values:
  - state IDLE; `grant` 0; `req_ready` 0; `hold_valid` 0; `hold_data` 0; `tx_data` 0; `tx_we` 0; counter 0.
  - `last` = NREQ-1, so requester 0 has first priority.
- Reset mid-operation: a staged byte is discarded. `rs232out` shares `rst`, so a character in flight is also aborted and the line returns to idle-high.

## Timing
- Arbitration: `req_valid` seen in IDLE at cycle t; `grant` high at t+1; first consume possible at t+1.
- Consume at t → `hold_valid` at t+1 → `tx_we` at t+1 if `tx_busy` low.
- `rs232out` raises `busy` the cycle after `we`, for one character time (about 2170 cycles at 115200 bps, 25 MHz).
- Steady state: one byte per character time. The producer is back-pressured via `req_ready` while a byte is staged and `tx_busy` is high.
- Simultaneous events:
  - `tx_we` and consume in the same cycle: staging is refilled, and `hold_valid` stays 1.
  - Release and a new request in the same cycle: the new request is arbitrated on the next cycle, from IDLE.
- Grant hand-off costs exactly one idle arbitration cycle.

## Structure
- Shared header: `LF` constant 8'h0A, state encodings, `IDLE_RELEASE` counter width (16).
- Sub-module `rs232out_rr_pick`:
  - combinational round-robin picker;
  - inputs: `req_valid[NREQ]`, `last`;
  - outputs: `found`, `idx`.
- The top level contains the FSM, staging register and idle counter. It is instantiated alongside `rs232out`.

## Test plan
- Reset, then requester 2 sends "A\n" (8'h41, 8'h0A), `tx_busy` tied 0 → `grant` = 4'b0100 one cycle after valid; `tx_we` pulses with 8'h41 then 8'h0A; `grant` returns to 0 after the LF is consumed.
- Requesters 0 and 1 both request at once, each sending 3-byte lines ending in LF → requester 0's full line first, then one idle cycle, then requester 1's line. Bytes are never interleaved.
- All four request continuously with single-byte lines of 8'h0A → grants rotate 0,1,2,3,0; each `tx_we` is separated by `tx_busy` from a real `rs232out` model.
- Owner sends 8'h41, then drops valid for 1023 cycles while requester 3 waits → release on cycle 1023 of idle; requester 3 is granted on the next arbitration.
- `tx_busy` held high for 100 cycles with a byte staged → `req_ready[own]` = 0 throughout. After `tx_busy` falls, the staged byte is written and the next byte is consumed in the same cycle.
- `rst` asserted while OWNED with a byte staged → next cycle `grant` = 0, `tx_we` = 0, `hold_valid` = 0; the first post-reset request from requester 1 wins over requester 0 only if 0 is idle.
